// File: rtl/text_window_renderer_pkg.sv
// ---------------------------------------------------------------------------
// text_pkg
//   Shared types and constants for the text window renderer: glyph cell
//   geometry, the character code type, the buffer-maintenance FSM states and
//   a window-span helper used by the beam geometry logic.
// ---------------------------------------------------------------------------
package text_pkg;

  localparam int CELL_PX = 8;   // glyph cell pitch in glyph dots (5 lit + 3 gap)
  localparam int GLYPH_W = 5;   // lit columns per cell; columns 5..7 are spacing

  typedef logic [7:0] char_t;

  localparam char_t FILL_DEFAULT = 8'd32;  // ASCII space

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } txt_state_t;

  // True when pos lies in [lo, lo+len). Done in int so a window that ends
  // past the 10-bit beam range still compares correctly.
  function automatic logic in_span(input logic [9:0] pos, input int lo, input int len);
    return (int'(pos) >= lo) && (int'(pos) < (lo + len));
  endfunction

endpackage

// File: rtl/text_window_renderer_buffer.sv
// ---------------------------------------------------------------------------
// text_buffer_dp
//   Character buffer: one write port, one registered read port.
//   A read and a write of the same cell on the same edge return the old
//   contents; the new value is seen from the next read.
// Ports:
//   clk, rst_n   clock, async active-low reset (read register only)
//   i_we         write enable
//   i_waddr      write cell index
//   i_wdata      character written
//   i_raddr      read cell index
//   o_rdata      registered read data
// ---------------------------------------------------------------------------
module text_buffer_dp
  import text_pkg::*;
#(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  char_t             i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output char_t             o_rdata
);

  char_t r_mem [DEPTH];
  char_t r_rdata;

  // Storage array: no reset, contents are defined by the clear sequence.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read register: samples the array before this edge's write lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= 8'd0;
    end else begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/text_window_renderer.sv
// ---------------------------------------------------------------------------
// text_window_renderer
//   Renders a COLS x ROWS character window on a VGA beam. Owns the character
//   buffer (valid/ready write port plus a FILL_CHAR clear sequence), drives
//   glyph lookups to an external combinational 5x8 glyph ROM and returns a
//   registered text-pixel stream with delayed de/hsync/vsync.
//
//   Alignment: beam inputs are registered (stage 1), the buffer read and the
//   glyph coordinates are registered (stage 2, visible on glyph_* two clocks
//   after the beam), and the ROM answer is captured in the output register
//   one clock later. de_o/hsync_o/vsync_o follow the same path so they stay
//   aligned with pix_on.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   hc, vc, de_i,
//   hsync_i, vsync_i      beam position and timing from the VGA generator
//   wr_valid/wr_ready,
//   wr_addr, wr_data      buffer write handshake (cell = row*COLS+col)
//   clr, busy             start / progress of the FILL_CHAR clear
//   glyph_sel/x/y         lookup to the glyph ROM
//   glyph_pixel           ROM answer (combinational)
//   pix_on, de_o,
//   hsync_o, vsync_o      aligned output stream to the colour mux
// ---------------------------------------------------------------------------
module text_window_renderer
  import text_pkg::*;
#(
  parameter int    COLS       = 32,
  parameter int    ROWS       = 4,
  parameter int    X0         = 0,
  parameter int    Y0         = 0,
  parameter int    SCALE_LOG2 = 1,
  parameter char_t FILL_CHAR  = FILL_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [9:0]                    hc,
  input  logic [9:0]                    vc,
  input  logic                          de_i,
  input  logic                          hsync_i,
  input  logic                          vsync_i,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [$clog2(COLS*ROWS)-1:0]  wr_addr,
  input  logic [7:0]                    wr_data,
  input  logic                          clr,
  output logic                          busy,
  output logic [7:0]                    glyph_sel,
  output logic [2:0]                    glyph_x,
  output logic [2:0]                    glyph_y,
  input  logic                          glyph_pixel,
  output logic                          pix_on,
  output logic                          de_o,
  output logic                          hsync_o,
  output logic                          vsync_o
);

  localparam int N      = COLS * ROWS;
  localparam int ADDR_W = $clog2(N);
  localparam int SH     = $clog2(CELL_PX) + SCALE_LOG2;  // beam px -> cell index
  localparam int WIN_W  = COLS * (CELL_PX << SCALE_LOG2);
  localparam int WIN_H  = ROWS * (CELL_PX << SCALE_LOG2);

  localparam logic [9:0]        X0_V = 10'(X0);
  localparam logic [9:0]        Y0_V = 10'(Y0);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

  // ---------------- buffer maintenance FSM ----------------
  txt_state_t        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_ptr, w_ptr_nxt;
  logic              r_busy, r_ready;

  // Next-state logic: clear walks every cell once; clr restarts it anywhere.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      CLEAR: begin
        if (clr) begin
          w_ptr_nxt = {ADDR_W{1'b0}};
        end else if (r_ptr == LAST) begin
          w_state_nxt = IDLE;
          w_ptr_nxt   = {ADDR_W{1'b0}};
        end else begin
          w_ptr_nxt = r_ptr + ADDR_W'(1);
        end
      end
      IDLE: begin
        if (clr) begin
          w_state_nxt = CLEAR;
          w_ptr_nxt   = {ADDR_W{1'b0}};
        end else begin
          w_ptr_nxt = r_ptr;
        end
      end
      default: begin
        w_state_nxt = CLEAR;
        w_ptr_nxt   = {ADDR_W{1'b0}};
      end
    endcase
  end

  // State register; busy/ready are decoded from the next state so they are flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= CLEAR;
      r_ptr   <= {ADDR_W{1'b0}};
      r_busy  <= 1'b1;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_busy  <= (w_state_nxt == CLEAR);
      r_ready <= (w_state_nxt == IDLE);
    end
  end

  assign busy     = r_busy;
  assign wr_ready = r_ready;

  // ---------------- buffer write port ----------------
  logic              w_addr_ok, w_we;
  logic [ADDR_W-1:0] w_waddr;
  char_t             w_wdata;

  // Clear owns the write port; an out-of-range host write handshakes but is dropped.
  always_comb begin
    w_addr_ok = (32'(wr_addr) < N);
    if (r_state == CLEAR) begin
      w_we    = 1'b1;
      w_waddr = r_ptr;
      w_wdata = FILL_CHAR;
    end else begin
      w_we    = wr_valid & r_ready & w_addr_ok;
      w_waddr = wr_addr;
      w_wdata = wr_data;
    end
  end

  // ---------------- beam geometry ----------------
  logic [9:0]        w_dx, w_dy, w_col, w_row;
  logic [2:0]        w_gx, w_gy;
  logic              w_in;
  logic [ADDR_W-1:0] w_raddr;

  // Cell index and glyph dot under the beam; address forced to 0 outside.
  always_comb begin
    w_dx    = hc - X0_V;
    w_dy    = vc - Y0_V;
    w_in    = in_span(hc, X0, WIN_W) && in_span(vc, Y0, WIN_H);
    w_col   = w_dx >> SH;
    w_row   = w_dy >> SH;
    w_gx    = 3'(w_dx >> SCALE_LOG2);
    w_gy    = 3'(w_dy >> SCALE_LOG2);
    w_raddr = w_in ? (ADDR_W'(w_row) * ADDR_W'(COLS) + ADDR_W'(w_col))
                   : {ADDR_W{1'b0}};
  end

  // ---------------- pipeline ----------------
  logic [ADDR_W-1:0] r_s1_addr;
  logic [2:0]        r_s1_gx, r_s1_gy, r_s2_gx, r_s2_gy;
  logic              r_s1_in, r_s1_de, r_s1_hs, r_s1_vs;
  logic              r_s2_in, r_s2_de, r_s2_hs, r_s2_vs;
  logic              r_pix, r_de, r_hs, r_vs;
  char_t             w_rdata;

  text_buffer_dp #(
    .DEPTH  (N),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (r_s1_addr),
    .o_rdata (w_rdata)
  );

  // Stages 1 and 2: beam side data travels alongside the buffer read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_addr <= {ADDR_W{1'b0}};
      r_s1_gx   <= 3'd0;
      r_s1_gy   <= 3'd0;
      r_s1_in   <= 1'b0;
      r_s1_de   <= 1'b0;
      r_s1_hs   <= 1'b0;
      r_s1_vs   <= 1'b0;
      r_s2_gx   <= 3'd0;
      r_s2_gy   <= 3'd0;
      r_s2_in   <= 1'b0;
      r_s2_de   <= 1'b0;
      r_s2_hs   <= 1'b0;
      r_s2_vs   <= 1'b0;
    end else begin
      r_s1_addr <= w_raddr;
      r_s1_gx   <= w_gx;
      r_s1_gy   <= w_gy;
      r_s1_in   <= w_in;
      r_s1_de   <= de_i;
      r_s1_hs   <= hsync_i;
      r_s1_vs   <= vsync_i;
      r_s2_gx   <= r_s1_gx;
      r_s2_gy   <= r_s1_gy;
      r_s2_in   <= r_s1_in;
      r_s2_de   <= r_s1_de;
      r_s2_hs   <= r_s1_hs;
      r_s2_vs   <= r_s1_vs;
    end
  end

  // Output register: capture the ROM answer; gap columns and clearing are dark.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix <= 1'b0;
      r_de  <= 1'b0;
      r_hs  <= 1'b0;
      r_vs  <= 1'b0;
    end else begin
      r_pix <= glyph_pixel & r_s2_in & r_s2_de & (r_s2_gx < 3'(GLYPH_W)) & ~r_busy;
      r_de  <= r_s2_de;
      r_hs  <= r_s2_hs;
      r_vs  <= r_s2_vs;
    end
  end

  assign glyph_sel = w_rdata;
  assign glyph_x   = r_s2_gx;
  assign glyph_y   = r_s2_gy;
  assign pix_on    = r_pix;
  assign de_o      = r_de;
  assign hsync_o   = r_hs;
  assign vsync_o   = r_vs;

endmodule
